// File: rtl/noc_arb_pkg.sv
// Shared arbiter constants: mode selectors, FSM state encoding, hold counter width.
// No logic; pure type/constant definitions.
// Not applicable (no datapath).
package noc_arb_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Width of the lock-duration counter; saturates at all-ones.
    localparam int HOLD_W = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: fixed priority from index 0, or rotating scan from ptr.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
module arb_pick #(
    parameter int PORTS = 3,
    parameter int IDX_W = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             mode_i,
    output logic [PORTS-1:0] winner_o,
    output logic [IDX_W-1:0] idx_o
);

    logic found;
    int   start;
    int   pos;

    // Scan upward from the start point, wrapping modulo PORTS; first set bit wins.
    always_comb begin
        winner_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        start    = mode_i ? int'(ptr_i) : 0;
        pos      = 0;
        for (int k = 0; k < PORTS; k++) begin
            pos = start + k;
            if (pos >= PORTS) begin
                pos = pos - PORTS;
            end
            if (!found && req_i[pos]) begin
                found         = 1'b1;
                winner_o[pos] = 1'b1;
                idx_o         = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/priority_arb_rr.sv
// Circuit-style arbiter: grants one requester and holds it until release, drop or hold-limit preemption.
// Latency: grant registered 1 cycle after request; one idle cycle between consecutive grants.
// Backpressure: requesters keep req_i high until granted; a grant is held while req stays high.
module priority_arb_rr
    import noc_arb_pkg::*;
#(
    parameter int PORTS    = 3,
    parameter int MODE     = 1,
    parameter int HOLD_MAX = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [PORTS-1:0]         req_i,
    input  logic [PORTS-1:0]         release_i,
    output logic [PORTS-1:0]         grant_o,
    output logic                     grant_valid_o,
    output logic [$clog2(PORTS)-1:0] grant_idx_o,
    output logic                     preempt_o
);

    localparam int IDX_W = $clog2(PORTS);
    // Counter value seen during the last permitted locked cycle.
    localparam logic [HOLD_W-1:0] HOLD_LIM = (HOLD_MAX > 0) ? HOLD_W'(HOLD_MAX - 1) : '0;

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [PORTS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic               grant_valid_q, grant_valid_d;
    logic               preempt_q, preempt_d;

    logic [PORTS-1:0]   pick_winner;
    logic [IDX_W-1:0]   pick_idx;
    logic               owner_release;
    logic               owner_drop;
    logic               other_req;
    logic               hold_hit;

    arb_pick #(
        .PORTS (PORTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .mode_i   (MODE == MODE_RR),
        .winner_o (pick_winner),
        .idx_o    (pick_idx)
    );

    // Release bits of non-owners are masked off by ANDing with the current grant.
    always_comb begin
        owner_release = |(release_i & grant_q);
        owner_drop    = ~|(req_i & grant_q);
        other_req     = |(req_i & ~grant_q);
        hold_hit      = (HOLD_MAX > 0) && (hold_cnt_q == HOLD_LIM) && other_req;
    end

    // Next-state and output computation; release/drop takes precedence over preemption.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        preempt_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    state_d       = ST_LOCKED;
                    grant_d       = pick_winner;
                    grant_idx_d   = pick_idx;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = '0;
                    if (MODE == MODE_RR) begin
                        ptr_d = (pick_idx == IDX_W'(PORTS - 1)) ? '0 : pick_idx + IDX_W'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (owner_release || owner_drop || hold_hit) begin
                    state_d       = ST_IDLE;
                    grant_d       = '0;
                    grant_idx_d   = '0;
                    grant_valid_d = 1'b0;
                    preempt_d     = !(owner_release || owner_drop);
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything including a live grant.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            hold_cnt_q    <= '0;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            preempt_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            preempt_q     <= preempt_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_valid_o = grant_valid_q;
    assign grant_idx_o   = grant_idx_q;
    assign preempt_o     = preempt_q;

endmodule

// File: tb/tb_priority_arb_rr.sv
// Directed bench: fixed-priority, round-robin and hold-limited arbiter instances.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_priority_arb_rr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // a: fixed priority, b: round-robin unlimited, c: round-robin with HOLD_MAX=4
    logic [2:0] req_a, rel_a, grant_a;  logic gv_a, pre_a;  logic [1:0] idx_a;
    logic [2:0] req_b, rel_b, grant_b;  logic gv_b, pre_b;  logic [1:0] idx_b;
    logic [2:0] req_c, rel_c, grant_c;  logic gv_c, pre_c;  logic [1:0] idx_c;

    int checks   = 0;
    int failures = 0;

    priority_arb_rr #(.PORTS(3), .MODE(0), .HOLD_MAX(0)) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req_a), .release_i(rel_a),
        .grant_o(grant_a), .grant_valid_o(gv_a), .grant_idx_o(idx_a), .preempt_o(pre_a));

    priority_arb_rr #(.PORTS(3), .MODE(1), .HOLD_MAX(0)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req_b), .release_i(rel_b),
        .grant_o(grant_b), .grant_valid_o(gv_b), .grant_idx_o(idx_b), .preempt_o(pre_b));

    priority_arb_rr #(.PORTS(3), .MODE(1), .HOLD_MAX(4)) u_c (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req_c), .release_i(rel_c),
        .grant_o(grant_c), .grant_valid_o(gv_c), .grant_idx_o(idx_c), .preempt_o(pre_c));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_a = '0; rel_a = '0; req_b = '0; rel_b = '0; req_c = '0; rel_c = '0;
        #3;
        checks++;
        if ({grant_a, gv_a, idx_a, pre_a} !== 7'b0) begin
            failures++; $display("FAIL reset_a: got %b want 0", {grant_a, gv_a, idx_a, pre_a});
        end
        checks++;
        if ({grant_b, gv_b, idx_b, pre_b} !== 7'b0) begin
            failures++; $display("FAIL reset_b: got %b want 0", {grant_b, gv_b, idx_b, pre_b});
        end
        checks++;
        if ({grant_c, gv_c, idx_c, pre_c} !== 7'b0) begin
            failures++; $display("FAIL reset_c: got %b want 0", {grant_c, gv_c, idx_c, pre_c});
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (grant_a !== 3'b000 || gv_a !== 1'b0) begin
            failures++; $display("FAIL idle_no_req: got %b/%b want 000/0", grant_a, gv_a);
        end
    endtask

    task automatic test_fixed();
        req_a = 3'b110;
        step();
        checks++;
        if (grant_a !== 3'b010 || idx_a !== 2'd1 || gv_a !== 1'b1) begin
            failures++; $display("FAIL fixed_first: got %b idx %0d vld %b want 010 idx 1 vld 1", grant_a, idx_a, gv_a);
        end
        rel_a = 3'b010; req_a = 3'b100;
        step();
        rel_a = 3'b000;
        checks++;
        if (grant_a !== 3'b000 || gv_a !== 1'b0 || idx_a !== 2'd0) begin
            failures++; $display("FAIL fixed_gap: got %b vld %b want 000 vld 0", grant_a, gv_a);
        end
        step();
        checks++;
        if (grant_a !== 3'b100 || idx_a !== 2'd2) begin
            failures++; $display("FAIL fixed_second: got %b idx %0d want 100 idx 2", grant_a, idx_a);
        end
        req_a = 3'b000;
        step();
        checks++;
        if (grant_a !== 3'b000) begin
            failures++; $display("FAIL fixed_drop: got %b want 000", grant_a);
        end
        req_a = 3'b101;
        step();
        checks++;
        if (grant_a !== 3'b001) begin
            failures++; $display("FAIL fixed_lowest: got %b want 001", grant_a);
        end
        req_a = 3'b000;
        step();
    endtask

    task automatic test_rr();
        logic [2:0] exp_seq [4];
        exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
        req_b = 3'b111;
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (grant_b !== exp_seq[i] || gv_b !== 1'b1) begin
                failures++; $display("FAIL rr_grant%0d: got %b want %b", i, grant_b, exp_seq[i]);
            end
            if (i < 3) begin
                rel_b = exp_seq[i];
                step();
                rel_b = 3'b000;
                checks++;
                if (grant_b !== 3'b000 || gv_b !== 1'b0) begin
                    failures++; $display("FAIL rr_gap%0d: got %b want 000", i, grant_b);
                end
                step();
            end
        end
    endtask

    task automatic test_ignore_release();
        rel_b = 3'b100;
        step();
        rel_b = 3'b000;
        checks++;
        if (grant_b !== 3'b001 || gv_b !== 1'b1) begin
            failures++; $display("FAIL foreign_rel2: got %b want 001", grant_b);
        end
        rel_b = 3'b010;
        step();
        rel_b = 3'b000;
        checks++;
        if (grant_b !== 3'b001 || idx_b !== 2'd0) begin
            failures++; $display("FAIL foreign_rel1: got %b want 001", grant_b);
        end
    endtask

    task automatic test_preempt();
        req_c = 3'b101;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (grant_c !== 3'b001 || pre_c !== 1'b0) begin
                failures++; $display("FAIL hold_cycle%0d: got %b pre %b want 001 pre 0", i, grant_c, pre_c);
            end
        end
        step();
        checks++;
        if (grant_c !== 3'b000 || pre_c !== 1'b1 || gv_c !== 1'b0) begin
            failures++; $display("FAIL preempt_pulse: got %b pre %b want 000 pre 1", grant_c, pre_c);
        end
        step();
        checks++;
        if (grant_c !== 3'b100 || pre_c !== 1'b0 || idx_c !== 2'd2) begin
            failures++; $display("FAIL after_preempt: got %b pre %b want 100 pre 0", grant_c, pre_c);
        end
        req_c = 3'b000;
        step();
        step();
    endtask

    task automatic test_no_preempt();
        int bad;
        bad = 0;
        req_c = 3'b010;
        step();
        checks++;
        if (grant_c !== 3'b010) begin
            failures++; $display("FAIL solo_grant: got %b want 010", grant_c);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (grant_c !== 3'b010 || pre_c !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL solo_hold: got %0d bad cycles want 0", bad);
        end
        req_c = 3'b000;
        step();
        step();
    endtask

    task automatic test_release_wins();
        req_c = 3'b101;
        step();
        checks++;
        if (grant_c !== 3'b100) begin
            failures++; $display("FAIL rw_grant: got %b want 100", grant_c);
        end
        step(); step(); step();
        rel_c = 3'b100;
        step();
        rel_c = 3'b000;
        checks++;
        if (grant_c !== 3'b000 || pre_c !== 1'b0) begin
            failures++; $display("FAIL rw_release: got %b pre %b want 000 pre 0", grant_c, pre_c);
        end
        step();
        checks++;
        if (grant_c !== 3'b001) begin
            failures++; $display("FAIL rw_next: got %b want 001", grant_c);
        end
        req_c = 3'b000;
        step();
    endtask

    task automatic test_reset_mid_grant();
        rst_n = 1'b0;
        #2;
        checks++;
        if (grant_b !== 3'b000 || gv_b !== 1'b0 || idx_b !== 2'd0 || pre_b !== 1'b0) begin
            failures++; $display("FAIL async_reset: got %b vld %b want 000 vld 0", grant_b, gv_b);
        end
        req_b = 3'b011;
        #4;
        rst_n = 1'b1;
        step();
        checks++;
        if (grant_b !== 3'b001 || idx_b !== 2'd0) begin
            failures++; $display("FAIL ptr_after_reset: got %b want 001", grant_b);
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr();
        test_ignore_release();
        test_preempt();
        test_no_preempt();
        test_release_wins();
        test_reset_mid_grant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
